// File: rtl/uart_prog_loader_pkg.sv
// Shared constants, FSM encoding and sizing helper for the UART program loader.
package uart_prog_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 24;

  localparam logic [WORD_W-1:0] DEF_START_WORD = 24'h0000FF;
  localparam logic [WORD_W-1:0] DEF_STOP_WORD  = 24'h00F0FF;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_IDLE     = 2'd1,
    ST_LOAD     = 2'd2
  } state_e;

  // Bits needed for a counter running 0..n-1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// UART byte stream in, instruction-memory write port and CPU control out.
interface uart_prog_loader_if
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              loading;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;

  // Loader side
  modport master (
    input  rx_data, rx_valid,
    output imem_we, imem_addr, imem_wdata, cpu_rst, loading, words_loaded, overflow
  );

  // Environment side (UART receiver, memory, CPU)
  modport slave (
    output rx_data, rx_valid,
    input  imem_we, imem_addr, imem_wdata, cpu_rst, loading, words_loaded, overflow
  );
endinterface

// File: rtl/uart_prog_loader_word_assembler.sv
// Packs three UART bytes (MSB first) into a 24-bit word; a stalled partial word is dropped.
module uart_word_assembler
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  localparam int unsigned     TMO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          r_byte_cnt;
  logic [2*BYTE_W-1:0] r_shift;
  logic [TMO_W-1:0]    r_tmo;
  logic [WORD_W-1:0]   r_word;
  logic                r_word_valid;
  logic                w_expire;

  assign w_expire = (r_byte_cnt != 2'd0) && (r_tmo == TMO_LAST);

  // A byte arriving on the expiry cycle starts a fresh word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt   <= 2'd0;
      r_shift      <= '0;
      r_tmo        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_rx_valid) begin
        r_tmo   <= '0;
        r_shift <= {r_shift[BYTE_W-1:0], i_rx_data};
        if (w_expire) begin
          r_byte_cnt <= 2'd1;
        end else if (r_byte_cnt == 2'd2) begin
          r_word       <= {r_shift, i_rx_data};
          r_word_valid <= 1'b1;
          r_byte_cnt   <= 2'd0;
        end else begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end else if (r_byte_cnt != 2'd0) begin
        if (w_expire) begin
          r_byte_cnt <= 2'd0;
          r_tmo      <= '0;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/uart_prog_loader.sv
// Program-download sequencer: START/STOP framed UART words are written to instruction memory,
// then the CPU is released from a timed reset.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 8,
  parameter logic [WORD_W-1:0] START_WORD     = DEF_START_WORD,
  parameter logic [WORD_W-1:0] STOP_WORD      = DEF_STOP_WORD,
  parameter int unsigned       RST_CYCLES     = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 200000
) (
  input logic clk,
  input logic rst,
  uart_prog_loader_if.master bus
);

  localparam int unsigned     RC_W    = cnt_width(RST_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  logic [WORD_W-1:0] w_word;
  logic              w_word_valid;
  logic              w_is_start;
  logic              w_is_stop;
  logic              w_mem_full;

  state_e            r_state;
  state_e            w_next_state;

  logic [ADDR_W:0]   r_addr_cnt;
  logic [RC_W-1:0]   r_rst_cnt;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [WORD_W-1:0] r_imem_wdata;
  logic              r_cpu_rst;
  logic              r_loading;
  logic              r_overflow;

  logic [ADDR_W:0]   w_addr_cnt_d;
  logic [RC_W-1:0]   w_rst_cnt_d;
  logic              w_imem_we_d;
  logic [ADDR_W-1:0] w_imem_addr_d;
  logic [WORD_W-1:0] w_imem_wdata_d;
  logic              w_cpu_rst_d;
  logic              w_loading_d;
  logic              w_overflow_d;

  uart_word_assembler #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (bus.rx_data),
    .i_rx_valid   (bus.rx_valid),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_is_start = w_word_valid && (w_word == START_WORD);
  assign w_is_stop  = w_word_valid && (w_word == STOP_WORD);
  // Counter is one bit wider than the address so a full memory is never mistaken for empty
  assign w_mem_full = r_addr_cnt[ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RST_HOLD;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST_HOLD: if (r_rst_cnt == RC_LAST) w_next_state = ST_IDLE;
      ST_IDLE:     if (w_is_start)           w_next_state = ST_LOAD;
      ST_LOAD:     if (w_is_stop)            w_next_state = ST_RST_HOLD;
      default:                               w_next_state = ST_RST_HOLD;
    endcase
  end

  // Next values for the registered datapath and outputs
  always_comb begin
    w_imem_we_d    = 1'b0;
    w_imem_addr_d  = r_imem_addr;
    w_imem_wdata_d = r_imem_wdata;
    w_addr_cnt_d   = r_addr_cnt;
    w_overflow_d   = r_overflow;
    w_rst_cnt_d    = r_rst_cnt;
    w_cpu_rst_d    = (w_next_state != ST_IDLE);
    w_loading_d    = (w_next_state == ST_LOAD);
    case (r_state)
      ST_RST_HOLD: begin
        w_rst_cnt_d = (r_rst_cnt == RC_LAST) ? '0 : r_rst_cnt + RC_W'(1);
      end
      ST_IDLE: begin
        if (w_is_start) begin
          w_addr_cnt_d = '0;
          w_overflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (w_is_stop) begin
          w_rst_cnt_d = '0;
        end else if (w_word_valid) begin
          if (w_mem_full) begin
            w_overflow_d = 1'b1;
          end else begin
            w_imem_we_d    = 1'b1;
            w_imem_addr_d  = r_addr_cnt[ADDR_W-1:0];
            w_imem_wdata_d = w_word;
            w_addr_cnt_d   = r_addr_cnt + (ADDR_W+1)'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_cnt   <= '0;
      r_rst_cnt    <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_rst    <= 1'b1;
      r_loading    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_addr_cnt   <= w_addr_cnt_d;
      r_rst_cnt    <= w_rst_cnt_d;
      r_imem_we    <= w_imem_we_d;
      r_imem_addr  <= w_imem_addr_d;
      r_imem_wdata <= w_imem_wdata_d;
      r_cpu_rst    <= w_cpu_rst_d;
      r_loading    <= w_loading_d;
      r_overflow   <= w_overflow_d;
    end
  end

  assign bus.imem_we      = r_imem_we;
  assign bus.imem_addr    = r_imem_addr;
  assign bus.imem_wdata   = r_imem_wdata;
  assign bus.cpu_rst      = r_cpu_rst;
  assign bus.loading      = r_loading;
  assign bus.words_loaded = r_addr_cnt;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: word table plus scoreboard of expected memory writes.
module tb_uart_prog_loader;
  import uart_prog_loader_pkg::*;

  localparam int unsigned AW  = 2;
  localparam int unsigned RC  = 16;
  localparam int unsigned TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(AW)) bus ();

  uart_prog_loader #(
    .ADDR_W         (AW),
    .START_WORD     (24'h0000FF),
    .STOP_WORD      (24'h00F0FF),
    .RST_CYCLES     (RC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [23:0] word;
    bit          partial;
    bit          exp_we;
    int          exp_addr;
    bit          exp_loading;
    bit          exp_cpu_rst;
    int          exp_words;
    bit          exp_ovf;
  } vec_t;

  typedef struct {
    int          addr;
    logic [23:0] data;
  } wr_t;

  wr_t  sb[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write the DUT makes must match the oldest expected write
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h with no write expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("write_data", 32'(bus.imem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Last byte of a word, returning right after the sampling edge
  task automatic send_last_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  initial begin
    int k;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    //            word         part we addr ld  crst words ovf
    vecs[0]  = '{24'hF0006C, 0,   0, 0,   0,  0,   0,    0};
    vecs[1]  = '{24'h0000FF, 0,   0, 0,   1,  1,   0,    0};
    vecs[2]  = '{24'hF0006C, 0,   1, 0,   1,  1,   1,    0};
    vecs[3]  = '{24'hACF28F, 0,   1, 1,   1,  1,   2,    0};
    vecs[4]  = '{24'h00F0FF, 0,   0, 0,   0,  0,   2,    0};
    vecs[5]  = '{24'h0000FF, 0,   0, 0,   1,  1,   0,    0};
    vecs[6]  = '{24'h000001, 1,   1, 0,   1,  1,   1,    0};
    vecs[7]  = '{24'h0000FF, 0,   1, 1,   1,  1,   2,    0};
    vecs[8]  = '{24'h123456, 0,   1, 2,   1,  1,   3,    0};
    vecs[9]  = '{24'hABCDEF, 0,   1, 3,   1,  1,   4,    0};
    vecs[10] = '{24'h777777, 0,   0, 0,   1,  1,   4,    1};
    vecs[11] = '{24'h00F0FF, 0,   0, 0,   0,  0,   4,    1};
    vecs[12] = '{24'h0000FF, 0,   0, 0,   1,  1,   0,    0};

    // Reset values while held
    repeat (3) @(negedge clk);
    check("rst_cpu_rst",  32'(bus.cpu_rst), 32'd1);
    check("rst_imem_we",  32'(bus.imem_we), 32'd0);
    check("rst_addr",     32'(bus.imem_addr), 32'd0);
    check("rst_wdata",    32'(bus.imem_wdata), 32'd0);
    check("rst_loading",  32'(bus.loading), 32'd0);
    check("rst_words",    32'(bus.words_loaded), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // CPU reset held for RC cycles after release
    @(posedge clk);
    #1 rst = 1'b1;
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_rst !== 1'b1) break;
    end
    check("reset_hold_cycles", 32'(k), 32'(RC));
    check("post_rst_loading", 32'(bus.loading), 32'd0);
    check("post_rst_words", 32'(bus.words_loaded), 32'd0);

    // Table of words and the state that must follow each
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].partial) begin
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (TMO + 10) @(posedge clk);
      end
      if (vecs[i].exp_we) sb.push_back('{vecs[i].exp_addr, vecs[i].word});
      send_word(vecs[i].word);
      repeat (RC + 8) @(negedge clk);
      check($sformatf("v%0d_loading", i), 32'(bus.loading), 32'(vecs[i].exp_loading));
      check($sformatf("v%0d_cpu_rst", i), 32'(bus.cpu_rst), 32'(vecs[i].exp_cpu_rst));
      check($sformatf("v%0d_words", i), 32'(bus.words_loaded), 32'(vecs[i].exp_words));
      check($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_pending_writes", i), 32'(sb.size()), 32'd0);
    end

    // Write latency: strobe two edges after the last byte is sampled
    sb.push_back('{0, 24'hFFFFFF});
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_last_byte(8'hFF);
    check("we_n_plus_1", 32'(bus.imem_we), 32'd0);
    @(posedge clk);
    #1;
    check("we_n_plus_2", 32'(bus.imem_we), 32'd1);
    check("addr_n_plus_2", 32'(bus.imem_addr), 32'd0);
    check("words_n_plus_2", 32'(bus.words_loaded), 32'd1);
    repeat (4) @(posedge clk);

    // STOP timing: cpu_rst low first after edge N+1+RC
    send_byte(8'h00);
    send_byte(8'hF0);
    send_last_byte(8'hFF);
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("stop_loading_drop", 32'(bus.loading), 32'd0);
      if (bus.cpu_rst !== 1'b1) break;
    end
    check("stop_hold_cycles", 32'(k), 32'(RC + 1));
    check("stop_words", 32'(bus.words_loaded), 32'd1);

    // Loader reset in the middle of a data word
    send_word(24'h0000FF);
    repeat (4) @(negedge clk);
    check("midrst_loading_before", 32'(bus.loading), 32'd1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("midrst_loading", 32'(bus.loading), 32'd0);
    check("midrst_words", 32'(bus.words_loaded), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'hEF);
    repeat (RC + 10) @(negedge clk);
    check("midrst_after_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("midrst_after_loading", 32'(bus.loading), 32'd0);
    check("final_pending_writes", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
